// File: rtl/step_decoder.sv
// Step-strobe decoder: turns five one-hot step strobes into a registered stage index and checks their order.
// Define STEP_DECODER_WDOG_EN to compile in the SYNC-state no-strobe watchdog (error code 3).
module step_decoder #(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTEP1,
    input  logic             iSTEP2,
    input  logic             iSTEP3,
    input  logic             iSTEP4,
    input  logic             iSTEP5,
    input  logic             iERR_CLR,
    output logic [2:0]       oSTAGE,
    output logic             oVALID,
    output logic             oCYCLE_DONE,
    output logic [CNT_W-1:0] oCYCLE_CNT,
    output logic             oERR,
    output logic [1:0]       oERR_CODE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_MULTI = 2'd1;
    localparam logic [1:0] CODE_ORDER = 2'd2;
    localparam logic [1:0] CODE_WDOG  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("step_decoder: CNT_W must be at least 1");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
        $error("step_decoder: WDOG_LIMIT must be at least 1");
    end

    logic [4:0] strobes;
    logic [2:0] hot_cnt;
    logic [2:0] hot_idx;
    logic       multi_hot;
    logic       single_hot;

    logic [1:0]       state,      state_d;
    logic [2:0]       exp_step,   exp_d;
    logic [2:0]       stage_d;
    logic             valid_d;
    logic             done_d;
    logic [CNT_W-1:0] cnt_d;
    logic             err_d;
    logic [1:0]       code_d;

`ifdef STEP_DECODER_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_cnt, wdog_d;
`endif

    assign strobes = {iSTEP5, iSTEP4, iSTEP3, iSTEP2, iSTEP1};

    // Population count plus the index of the (only, when single) high strobe, numbered 1..5.
    always_comb begin
        hot_cnt = 3'd0;
        hot_idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (strobes[i]) begin
                hot_cnt = hot_cnt + 3'd1;
                hot_idx = 3'(i + 1);
            end
        end
    end

    assign multi_hot  = (hot_cnt > 3'd1);
    assign single_hot = (hot_cnt == 3'd1);

    always_comb begin
        // NOTE: every next-value signal gets a default here so no branch can infer a latch.
        state_d = state;
        exp_d   = exp_step;
        stage_d = oSTAGE;
        valid_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = oCYCLE_CNT;
        err_d   = oERR;
        code_d  = oERR_CODE;
`ifdef STEP_DECODER_WDOG_EN
        wdog_d  = '0;
`endif

        case (state)
            ST_IDLE: begin
                stage_d = 3'd0;
                if (multi_hot) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = CODE_MULTI;
                end else if (single_hot && hot_idx == 3'd1) begin
                    state_d = ST_SYNC;
                    stage_d = 3'd1;
                    valid_d = 1'b1;
                    exp_d   = 3'd2;
                end
            end

            ST_SYNC: begin
                if (multi_hot) begin
                    state_d = ST_ERR;
                    stage_d = 3'd0;
                    err_d   = 1'b1;
                    code_d  = CODE_MULTI;
                end else if (single_hot) begin
                    if (hot_idx == exp_step) begin
                        stage_d = hot_idx;
                        valid_d = 1'b1;
                        exp_d   = (hot_idx == 3'd5) ? 3'd1 : hot_idx + 3'd1;
                        if (hot_idx == 3'd5) begin
                            done_d = 1'b1;
                            cnt_d  = oCYCLE_CNT + CNT_ONE;
                        end
                    end else begin
                        state_d = ST_ERR;
                        stage_d = 3'd0;
                        err_d   = 1'b1;
                        code_d  = CODE_ORDER;
                    end
                end else begin
`ifdef STEP_DECODER_WDOG_EN
                    // The edge that would bring the idle run up to WDOG_LIMIT is the error edge.
                    if (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
                        state_d = ST_ERR;
                        stage_d = 3'd0;
                        err_d   = 1'b1;
                        code_d  = CODE_WDOG;
                    end else begin
                        wdog_d = wdog_cnt + WDOG_W'(1);
                    end
`endif
                end
            end

            ST_ERR: begin
                stage_d = 3'd0;
                if (iERR_CLR) begin
                    state_d = ST_IDLE;
                    exp_d   = 3'd1;
                    err_d   = 1'b0;
                    code_d  = CODE_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                stage_d = 3'd0;
                exp_d   = 3'd1;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= ST_IDLE;
            exp_step    <= 3'd1;
            oSTAGE      <= 3'd0;
            oVALID      <= 1'b0;
            oCYCLE_DONE <= 1'b0;
            oCYCLE_CNT  <= '0;
            oERR        <= 1'b0;
            oERR_CODE   <= CODE_NONE;
`ifdef STEP_DECODER_WDOG_EN
            wdog_cnt    <= '0;
`endif
        end else begin
            state       <= state_d;
            exp_step    <= exp_d;
            oSTAGE      <= stage_d;
            oVALID      <= valid_d;
            oCYCLE_DONE <= done_d;
            oCYCLE_CNT  <= cnt_d;
            oERR        <= err_d;
            oERR_CODE   <= code_d;
`ifdef STEP_DECODER_WDOG_EN
            wdog_cnt    <= wdog_d;
`endif
        end
    end

endmodule

// File: doc/step_decoder.md
# step_decoder

Consumer-side decoder for the five one-hot instruction-step strobes produced by the processor's step/clock generator. Samples the strobes every clock, converts them to a registered binary stage index, checks that they arrive strictly in the order 1→2→3→4→5→1, counts completed instruction cycles and flags protocol violations with a sticky error code. Sits between the step generator and the datapath control / debug logic, so downstream blocks use one stage bus instead of five strobes.

## Interface
- CNT_W, 16: width of the completed-cycle counter.
- WDOG_LIMIT, 8: consecutive no-strobe cycles in SYNC before a watchdog error. Used only when the watchdog is compiled in.
- iCLK  in  1  clock; all logic on posedge.
- iRST  in  1  reset; synchronous, active-high.
- iSTEP1..iSTEP5  in  1 each  step strobes; exactly one high per cycle in normal operation.
- iERR_CLR  in  1  clears error state; synchronous, one-cycle pulse or level.
- oSTAGE  out  3  stage index of the last accepted strobe (1..5); 0 = none.
- oVALID  out  1  oSTAGE holds an in-order stage.
- oCYCLE_DONE  out  1  one-cycle pulse when an in-order STEP5 is accepted.
- oCYCLE_CNT  out  CNT_W  completed instruction cycles, modulo 2^CNT_W.
- oERR  out  1  sticky error flag.
- oERR_CODE  out  2  0 none, 1 multi-hot, 2 out-of-order, 3 watchdog.

## Operation
- States: IDLE (waiting for first STEP1), SYNC (tracking; holds expected next step E), ERR (locked).
- Reset values: state IDLE, E=1, oSTAGE=0, oVALID=0, oCYCLE_DONE=0, oCYCLE_CNT=0, oERR=0, oERR_CODE=0, watchdog count 0.
- Priority per edge: iRST > iERR_CLR > multi-hot check > order check > watchdog.
- Multi-hot (two or more strobes high) in any state except ERR → ERR, code 1.
- IDLE: single STEP1 → SYNC, oSTAGE=1, oVALID=1, E=2. Single STEP2..5 or no strobe → stay IDLE, outputs 0, no error.
- SYNC, single strobe k == E → oSTAGE=k, oVALID=1, E=k+1 (5 wraps to 1). k=5 also: oCYCLE_DONE=1, oCYCLE_CNT+1 (wraps to 0 past 2^CNT_W−1).
- SYNC, single strobe k != E → ERR, code 2.
- SYNC, no strobe → oSTAGE and E held, oVALID=0, no counter change.
- ERR: oSTAGE=0, oVALID=0, oCYCLE_DONE=0, oCYCLE_CNT frozen, oERR=1, code held; further violations do not overwrite the code.
- iERR_CLR in ERR → IDLE, oERR=0, code 0, E=1; counter retained. iERR_CLR outside ERR has no effect. Strobes on the clearing edge are ignored.
- iRST mid-cycle (any state) → all reset values on that edge; counter cleared.

## Timing
- All outputs registered; latency 1 clock from strobe sample to oSTAGE/oVALID/oCYCLE_DONE/oCYCLE_CNT.
- Error detected on edge N → oERR=1 and oSTAGE=0 visible after edge N.
- oCYCLE_DONE never high for two consecutive cycles under legal input.
- No combinational path from inputs to outputs.

## Configuration
- STEP_DECODER_WDOG_EN defined: in SYNC a counter increments on each no-strobe cycle and clears on any strobe; reaching WDOG_LIMIT → ERR, code 3 on that edge. Counter cleared in IDLE, ERR and on reset.
- Undefined: no watchdog logic; no-strobe cycles in SYNC hold state indefinitely; code 3 is never produced.

## Test plan
- Reset, then 3 full generator rounds (STEP1..STEP5 one per cycle) → oSTAGE 1,2,3,4,5 repeating, one cycle late; oCYCLE_DONE pulses 3 times; oCYCLE_CNT=3; oERR=0.
- STEP3 then STEP4 from IDLE → oVALID=0, oERR=0; then STEP1 → oSTAGE=1, oVALID=1.
- STEP1, STEP2, STEP4 → oERR=1, oERR_CODE=2, oSTAGE=0 next cycle; oCYCLE_CNT unchanged; iERR_CLR → oERR=0, IDLE, resync on STEP1.
- STEP2 and STEP3 high together in SYNC → oERR_CODE=1; a later STEP5 skip does not change the code.
- CNT_W=4, 16 legal rounds → oCYCLE_CNT wraps to 0 on the 16th oCYCLE_DONE; iRST during STEP3 → all outputs 0 next cycle.
- With STEP_DECODER_WDOG_EN, WDOG_LIMIT=8: STEP1, then 8 idle cycles → oERR_CODE=3; without macro → no error, oSTAGE holds 1, oVALID=0.
